// File: rtl/qoi_pkg.sv
// Shared constants, state encoding and framing helpers for the QOI chunk serializer.
package qoi_pkg;

  localparam logic [7:0] QOI_OP_INDEX = 8'h00;
  localparam logic [7:0] QOI_OP_DIFF  = 8'h40;
  localparam logic [7:0] QOI_OP_LUMA  = 8'h80;
  localparam logic [7:0] QOI_OP_RUN   = 8'hC0;
  localparam logic [7:0] QOI_OP_RGB   = 8'hFE;
  localparam logic [7:0] QOI_OP_RGBA  = 8'hFF;

  localparam logic [31:0] QOI_MAGIC      = 32'h716F6966;
  localparam int unsigned QOI_HEADER_LEN = 14;
  localparam logic [63:0] QOI_END_MARKER = 64'h0000_0000_0000_0001;
  localparam int unsigned QOI_END_LEN    = 8;
  localparam int unsigned QOI_MAX_CHUNK  = 5;

  typedef enum logic [2:0] {
    QOI_IDLE    = 3'd0,
    QOI_HEADER  = 3'd1,
    QOI_DATA    = 3'd2,
    QOI_DRAIN   = 3'd3,
    QOI_TRAILER = 3'd4
  } qoi_state_e;

  localparam logic [2:0] ST_IDLE    = 3'(QOI_IDLE);
  localparam logic [2:0] ST_HEADER  = 3'(QOI_HEADER);
  localparam logic [2:0] ST_DATA    = 3'(QOI_DATA);
  localparam logic [2:0] ST_DRAIN   = 3'(QOI_DRAIN);
  localparam logic [2:0] ST_TRAILER = 3'(QOI_TRAILER);

  // Header byte idx of magic, width, height (big-endian), channels, colorspace.
  function automatic logic [7:0] qoi_header_byte(input logic [3:0]  idx,
                                                 input logic [31:0] w,
                                                 input logic [31:0] h,
                                                 input logic [7:0]  cs);
    logic [111:0] hdr;
    hdr = {QOI_MAGIC, w, h, 8'h04, cs};
    if (idx < 4'(QOI_HEADER_LEN)) return hdr[8*(13-int'(idx)) +: 8];
    return 8'h00;
  endfunction

  function automatic logic [7:0] qoi_end_byte(input logic [2:0] idx);
    return QOI_END_MARKER[8*(7-int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/qoi_byte_fifo.sv
// Byte FIFO: writes 0..5 bytes per cycle at the write pointer, pops at most one byte per cycle.
module qoi_byte_fifo
  import qoi_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [QOI_MAX_CHUNK-1:0][7:0] wr_data,
  input  logic [2:0]                    wr_len,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(QOI_MAX_CHUNK); i++) begin
      if (3'(i) < wr_len) mem[wr_ptr + AW'(i)] <= wr_data[i];
    end
  end

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_len);
      rd_ptr <= rd_ptr + AW'(rd_en);
      count  <= count + CW'(wr_len) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/qoi_chunk_serializer.sv
// Serializes 0..5-byte encoder chunks into a 1 byte/cycle valid/ready stream.
// Define QOI_SERIALIZER_FRAMING_EN to wrap each image in the QOI header and end marker.
module qoi_chunk_serializer
  import qoi_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [QOI_MAX_CHUNK-1:0][7:0] chunk,
  input  logic [2:0]                    chunk_len,
  input  logic                          start,
  input  logic                          done,
  input  logic [31:0]                   width,
  input  logic [31:0]                   height,
  input  logic [7:0]                    colorspace,
  output logic [7:0]                    out_byte,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          in_ready,
  output logic                          overflow,
  output logic                          busy
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [2:0]    state, state_d;
  logic [CW-1:0] count, free;
  logic [7:0]    rd_data, out_byte_d;
  logic          out_valid_d, out_last_d, busy_d;
  logic          pop, wr_open, len_bad, load;
  logic [2:0]    wr_len;

`ifdef QOI_SERIALIZER_FRAMING_EN
  logic [3:0]  cnt, cnt_d;
  logic [31:0] width_q, width_d, height_q, height_d;
  logic [7:0]  cs_q, cs_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{width, height, colorspace};
`endif

  qoi_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_data (chunk),
    .wr_len  (wr_len),
    .rd_en   (pop),
    .rd_data (rd_data),
    .count   (count)
  );

  // Chunks are all-or-nothing: a chunk that does not fit is dropped whole.
  assign free     = CW'(DEPTH) - count;
  assign wr_open  = (state == ST_HEADER) || (state == ST_DATA) || (state == ST_DRAIN);
  assign len_bad  = (chunk_len > 3'(QOI_MAX_CHUNK)) || (CW'(chunk_len) > free);
  assign wr_len   = (wr_open && !len_bad) ? chunk_len : 3'd0;
  assign load     = !out_valid || out_ready;
  assign in_ready = free >= CW'(QOI_MAX_CHUNK);
  assign busy_d   = state_d != ST_IDLE;

  always_comb begin
    state_d     = state;
    out_byte_d  = out_byte;
    out_valid_d = out_valid;
    out_last_d  = out_last;
    pop         = 1'b0;
`ifdef QOI_SERIALIZER_FRAMING_EN
    cnt_d    = cnt;
    width_d  = width_q;
    height_d = height_q;
    cs_d     = cs_q;
`endif
    if (load) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    case (state)
      ST_IDLE: begin
        if (start) begin
`ifdef QOI_SERIALIZER_FRAMING_EN
          state_d  = ST_HEADER;
          cnt_d    = '0;
          width_d  = width;
          height_d = height;
          cs_d     = colorspace;
`else
          state_d = ST_DATA;
`endif
        end
      end
`ifdef QOI_SERIALIZER_FRAMING_EN
      ST_HEADER: begin
        if (load) begin
          out_byte_d  = qoi_header_byte(cnt, width_q, height_q, cs_q);
          out_valid_d = 1'b1;
          cnt_d       = cnt + 4'd1;
          if (cnt == 4'(QOI_HEADER_LEN - 1)) state_d = ST_DATA;
        end
      end
      // After the marker is loaded, stay until the final byte is accepted.
      ST_TRAILER: begin
        if (load) begin
          if (cnt < 4'(QOI_END_LEN)) begin
            out_byte_d  = qoi_end_byte(3'(cnt));
            out_valid_d = 1'b1;
            out_last_d  = cnt == 4'(QOI_END_LEN - 1);
            cnt_d       = cnt + 4'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
`endif
      ST_DATA, ST_DRAIN: begin
        if (load && count != '0) begin
          pop         = 1'b1;
          out_byte_d  = rd_data;
          out_valid_d = 1'b1;
`ifndef QOI_SERIALIZER_FRAMING_EN
          out_last_d  = (state == ST_DRAIN || done) && count == CW'(1) && wr_len == 3'd0;
`endif
        end
        if (state == ST_DATA) begin
          if (done) state_d = ST_DRAIN;
        end else if (count == '0 && !out_valid && wr_len == 3'd0) begin
`ifdef QOI_SERIALIZER_FRAMING_EN
          state_d = ST_TRAILER;
          cnt_d   = '0;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      out_byte  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
`ifdef QOI_SERIALIZER_FRAMING_EN
      cnt      <= '0;
      width_q  <= '0;
      height_q <= '0;
      cs_q     <= '0;
`endif
    end else begin
      state     <= state_d;
      out_byte  <= out_byte_d;
      out_valid <= out_valid_d;
      out_last  <= out_last_d;
      overflow  <= overflow | (wr_open && len_bad);
      busy      <= busy_d;
`ifdef QOI_SERIALIZER_FRAMING_EN
      cnt      <= cnt_d;
      width_q  <= width_d;
      height_q <= height_d;
      cs_q     <= cs_d;
`endif
    end
  end

endmodule

// File: tb/tb_qoi_chunk_serializer.sv
// Directed bench for qoi_chunk_serializer (DEPTH=16); framing run when QOI_SERIALIZER_FRAMING_EN is defined.
module tb_qoi_chunk_serializer;
  import qoi_pkg::*;

  logic                          clk = 1'b0;
  logic                          rst = 1'b0;
  logic [QOI_MAX_CHUNK-1:0][7:0] chunk = '0;
  logic [2:0]                    chunk_len = 3'd0;
  logic                          start = 1'b0;
  logic                          done = 1'b0;
  logic [31:0]                   width = '0;
  logic [31:0]                   height = '0;
  logic [7:0]                    colorspace = '0;
  logic [7:0]                    out_byte;
  logic                          out_valid;
  logic                          out_ready = 1'b1;
  logic                          out_last;
  logic                          in_ready;
  logic                          overflow;
  logic                          busy;

  qoi_chunk_serializer #(.DEPTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .chunk      (chunk),
    .chunk_len  (chunk_len),
    .start      (start),
    .done       (done),
    .width      (width),
    .height     (height),
    .colorspace (colorspace),
    .out_byte   (out_byte),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .in_ready   (in_ready),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] got_b[$];
  logic       got_l[$];
  int         got_c[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record each handshake that will complete on the coming rising edge.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      got_b.push_back(out_byte);
      got_l.push_back(out_last);
      got_c.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int len, input int base);
    for (int i = 0; i < 5; i++) chunk[i] = (i < len) ? 8'(base + i) : 8'h00;
    chunk_len = 3'(len);
    tick();
    chunk_len = 3'd0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic clear_got();
    got_b.delete();
    got_l.delete();
    got_c.delete();
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_stream(input string tag, input logic [7:0] exp[$], input bit want_last);
    int nl = 0;
    chk({tag, "_len"}, 32'(got_b.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got_b.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(got_b[i]), 32'(exp[i]));
    foreach (got_l[i]) if (got_l[i]) nl++;
    chk({tag, "_nlast"}, 32'(nl), want_last ? 32'd1 : 32'd0);
    if (want_last && got_l.size() > 0)
      chk({tag, "_lastpos"}, 32'(got_l[got_l.size()-1]), 32'd1);
  endtask

  initial begin
    logic [7:0] exp[$];
    logic [7:0] ref_q[$];
    int maxgap;
    int mism;
    int len;

    // Reset values
    repeat (3) tick();
    chk("rst_out_byte", 32'(out_byte), 32'h00);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b1;
    tick();

`ifdef QOI_SERIALIZER_FRAMING_EN
    // Framed empty image
    clear_got();
    width = 32'h280;
    height = 32'h1E0;
    colorspace = 8'h00;
    out_ready = 1'b1;
    pulse_start();
    chk("frm_busy", 32'(busy), 32'd1);
    repeat (16) tick();
    pulse_done();
    wait_idle("frm", 80);
    exp = {8'h71, 8'h6F, 8'h69, 8'h66, 8'h00, 8'h00, 8'h02, 8'h80,
           8'h00, 8'h00, 8'h01, 8'hE0, 8'h04, 8'h00,
           8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    check_stream("frm", exp, 1'b1);
`else
    // Variable chunk lengths 1,5,0,2,4
    clear_got();
    out_ready = 1'b1;
    pulse_start();
    chk("var_busy", 32'(busy), 32'd1);
    wr(1, 8'h10);
    chk("lat_wrcycle_valid", 32'(out_valid), 32'd0);
    wr(5, 8'h20);
    chk("lat_next_valid", 32'(out_valid), 32'd1);
    chk("lat_next_byte", 32'(out_byte), 32'h10);
    wr(0, 8'h00);
    wr(2, 8'h30);
    wr(4, 8'h40);
    pulse_done();
    wait_idle("var", 50);
    exp = {8'h10, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h30, 8'h31, 8'h40, 8'h41, 8'h42, 8'h43};
    check_stream("var", exp, 1'b1);
    maxgap = 1;
    for (int i = 1; i < got_c.size(); i++)
      if (got_c[i] - got_c[i-1] > maxgap) maxgap = got_c[i] - got_c[i-1];
    chk("var_gap", 32'(maxgap), 32'd1);

    // Backpressure, in_ready threshold and overflow
    clear_got();
    out_ready = 1'b0;
    pulse_start();
    wr(1, 8'h1F);
    tick();
    chk("bp_hold_valid0", 32'(out_valid), 32'd1);
    chk("bp_hold_byte0", 32'(out_byte), 32'h1F);
    wr(5, 8'h20);
    wr(5, 8'h25);
    chk("in_ready_cnt10", 32'(in_ready), 32'd1);
    wr(5, 8'h2A);
    chk("in_ready_cnt15", 32'(in_ready), 32'd0);
    chk("ovf_before", 32'(overflow), 32'd0);
    wr(2, 8'hEE);
    chk("ovf_set", 32'(overflow), 32'd1);
    repeat (6) tick();
    chk("bp_hold_valid10", 32'(out_valid), 32'd1);
    chk("bp_hold_byte10", 32'(out_byte), 32'h1F);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_count_kept", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    pulse_done();
    wait_idle("bp", 60);
    exp = {8'h1F, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
           8'h27, 8'h28, 8'h29, 8'h2A, 8'h2B, 8'h2C, 8'h2D, 8'h2E};
    check_stream("bp", exp, 1'b1);

    // Async reset with FIFO half full
    out_ready = 1'b0;
    pulse_start();
    wr(5, 8'h80);
    wr(5, 8'h85);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out_byte", 32'(out_byte), 32'h00);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_last", 32'(out_last), 32'd0);
    chk("arst_overflow", 32'(overflow), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    clear_got();
    out_ready = 1'b1;
    wr(3, 8'h60);
    for (int i = 0; i < 5; i++) chunk[i] = 8'(8'h70 + i);
    chunk_len = 3'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    chunk_len = 3'd0;
    wr(3, 8'h50);
    pulse_done();
    wait_idle("arst", 40);
    exp = {8'h50, 8'h51, 8'h52};
    check_stream("arst", exp, 1'b1);
    chk("idle_chunk_no_ovf", 32'(overflow), 32'd0);

    // Random chunks under random backpressure
    clear_got();
    ref_q.delete();
    pulse_start();
    for (int n = 0; n < 100; n++) begin
      out_ready = 1'($urandom_range(0, 1));
      len = in_ready ? int'($urandom_range(0, 5)) : 0;
      for (int i = 0; i < 5; i++) begin
        chunk[i] = 8'($urandom);
        if (i < len) ref_q.push_back(chunk[i]);
      end
      chunk_len = 3'(len);
      tick();
    end
    chunk_len = 3'd0;
    out_ready = 1'b1;
    pulse_done();
    wait_idle("rnd", 400);
    chk("rnd_len", 32'(got_b.size()), 32'(ref_q.size()));
    mism = 0;
    for (int i = 0; i < ref_q.size() && i < got_b.size(); i++)
      if (got_b[i] !== ref_q[i]) mism++;
    chk("rnd_mismatch", 32'(mism), 32'd0);
    chk("rnd_no_ovf", 32'(overflow), 32'd0);

    // Illegal chunk length
    clear_got();
    pulse_start();
    chunk_len = 3'd6;
    tick();
    chunk_len = 3'd0;
    chk("len6_ovf", 32'(overflow), 32'd1);
    pulse_done();
    wait_idle("len6", 20);
    chk("len6_dropped", 32'(got_b.size()), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
